// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a checksummed program into the 32x16 instruction memory and serves registered fetches
module program_loader #(
  parameter int n    = 16,
  parameter int nbit = 5
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            Start,
  input  logic [nbit:0]   Length,
  input  logic [n-1:0]    WordIn,
  input  logic            WordValid,
  output logic            WordReady,
  input  logic [nbit-1:0] address_bits,
  output logic [n-1:0]    Datain,
  output logic            Run,
  output logic            Loaded,
  output logic            Error,
  output logic [nbit:0]   WordCount
);

  localparam int DEPTH = 1 << nbit;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_READY, S_ERROR} state_t;

  state_t          state_q, state_d;
  logic [nbit:0]   len_q, len_d;
  logic [nbit:0]   cnt_q, cnt_d;
  logic [n-1:0]    sum_q, sum_d;
  logic [n-1:0]    datain_q;
  logic [n-1:0]    mem_q [DEPTH];
  logic            xfer;
  logic            wr_en;
  logic            len_ok;
  logic [n-1:0]    chk_total;

  // Ready is decoded from state alone so WordValid never reaches WordReady combinationally.
  assign WordReady = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign xfer      = WordValid && WordReady;
  assign chk_total = sum_q + WordIn;
  assign len_ok    = (Length != '0) && (Length <= (nbit+1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          sum_d = sum_q + WordIn;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (chk_total == '0) ? S_READY : S_ERROR;
      end
      default: begin
        if (Start) begin
          if (len_ok) begin
            len_d   = Length;
            cnt_d   = '0;
            sum_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      datain_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      datain_q <= mem_q[address_bits];
    end
  end

  // Memory is deliberately not reset; a same-address read returns the pre-write word.
  always_ff @(posedge Clock) begin
    if (wr_en && !Clear) mem_q[cnt_q[nbit-1:0]] <= WordIn;
  end

  assign Datain    = datain_q;
  assign Run       = (state_q == S_READY);
  assign Loaded    = (state_q == S_READY);
  assign Error     = (state_q == S_ERROR);
  assign WordCount = cnt_q;

endmodule
